// File: rtl/rps_pkg.sv
// Shared types and helpers for the rock-paper-scissors move arbiter.
package rps_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        ROCK     = 2'd1,
        PAPER    = 2'd2,
        SCISSORS = 2'd3
    } move_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REVEAL  = 2'd2
    } arb_state_t;

    // Button vector {scissors, paper, rock}; anything not one-hot is NONE.
    function automatic move_t onehot_to_move(input logic [2:0] btn);
        move_t m;
        case (btn)
            3'b001:  m = ROCK;
            3'b010:  m = PAPER;
            3'b100:  m = SCISSORS;
            default: m = NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/move_debouncer.sv
// Per-player debouncer: arms on a released sample, then locks the first
// one-hot press held stable for DEBOUNCE_CYCLES samples.
module move_debouncer
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [2:0] btn,
    output move_t      move,
    output logic       locked
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);

    logic          armed;
    logic [2:0]    prev;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          valid;
    logic          active;

    assign valid  = (onehot_to_move(btn) != NONE);
    assign active = enable && !locked;

    always_comb begin
        count_next = count;
        if (armed) begin
            if (!valid) begin
                count_next = '0;
            end else if (btn == prev && count != '0) begin
                count_next = (count == TARGET) ? count : count + CW'(1);
            end else begin
                count_next = CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            armed  <= 1'b0;
            prev   <= 3'b000;
            count  <= '0;
            locked <= 1'b0;
            move   <= NONE;
        end else if (active) begin
            prev  <= btn;
            count <= count_next;
            // A release must be seen before any press may count.
            if (btn == 3'b000) begin
                armed <= 1'b1;
            end
            if (armed && count_next == TARGET) begin
                locked <= 1'b1;
                move   <= onehot_to_move(btn);
            end
        end
    end

endmodule

// File: rtl/rps_move_arbiter.sv
// Round sequencer: IDLE -> COLLECT -> REVEAL with a valid/ack handoff
// of both locked moves to the scoring logic.
module rps_move_arbiter
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] p1_btn,
    input  logic [2:0] p2_btn,
    input  logic       start,
    input  logic       round_ack,
    output logic [1:0] p1_move,
    output logic [1:0] p2_move,
    output logic       p1_locked,
    output logic       p2_locked,
    output logic       round_valid,
    output logic       busy
);

    arb_state_t state;
    arb_state_t state_next;
    move_t      m1;
    move_t      m2;
    logic       enable;
    logic       clear;

    assign enable = (state == COLLECT);
    assign clear  = (state == REVEAL) && round_ack;

    move_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_p1 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .btn    (p1_btn),
        .move   (m1),
        .locked (p1_locked)
    );

    move_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_p2 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .btn    (p2_btn),
        .move   (m2),
        .locked (p2_locked)
    );

    assign p1_move = m1;
    assign p2_move = m2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (p1_locked && p2_locked) state_next = REVEAL;
            REVEAL:  if (round_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        round_valid = (state == REVEAL);
        busy        = (state != IDLE);
    end

endmodule

// File: tb/tb_rps_move_arbiter.sv
// Bench for rps_move_arbiter: vector table, directed corners,
// and randomized traffic against a history-based reference model.
module tb_rps_move_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] p1_btn;
    logic [2:0] p2_btn;
    logic       start;
    logic       round_ack;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       p1_locked;
    logic       p2_locked;
    logic       round_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rps_move_arbiter #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p1_btn      (p1_btn),
        .p2_btn      (p2_btn),
        .start       (start),
        .round_ack   (round_ack),
        .p1_move     (p1_move),
        .p2_move     (p2_move),
        .p1_locked   (p1_locked),
        .p2_locked   (p2_locked),
        .round_valid (round_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 collecting, 2 revealing.
    int         phase;
    bit         armed [2];
    bit         lk [2];
    logic [1:0] mv [2];
    logic [2:0] h0 [$];
    logic [2:0] h1 [$];

    function automatic int trailing(input logic [2:0] q[$]);
        int n = 0;
        logic [2:0] last;
        if (q.size() == 0) return 0;
        last = q[q.size()-1];
        if ($countones(last) != 1) return 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] != last) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            armed[p] = 0;
            lk[p] = 0;
            mv[p] = 2'd0;
        end
        h0.delete();
        h1.delete();
    endtask

    task automatic player_step(input int p, input logic [2:0] b);
        int run;
        if (lk[p]) return;
        if (armed[p]) begin
            if (p == 0) begin
                h0.push_back(b);
                if (h0.size() > 16) void'(h0.pop_front());
                run = trailing(h0);
            end else begin
                h1.push_back(b);
                if (h1.size() > 16) void'(h1.pop_front());
                run = trailing(h1);
            end
            if (run >= N) begin
                lk[p] = 1;
                mv[p] = (b == 3'b001) ? 2'd1 :
                        (b == 3'b010) ? 2'd2 : 2'd3;
            end
        end
        if (b == 3'b000) begin
            armed[p] = 1;
            if (p == 0) h0.delete();
            else h1.delete();
        end
    endtask

    task automatic model_step(
        input logic r, input logic s, input logic a,
        input logic [2:0] x, input logic [2:0] y
    );
        bit both;
        if (!r) begin
            model_clear();
            phase = 0;
        end else if (phase == 0) begin
            if (s) phase = 1;
        end else if (phase == 1) begin
            both = lk[0] && lk[1];
            player_step(0, x);
            player_step(1, y);
            if (both) phase = 2;
        end else begin
            if (a) begin
                phase = 0;
                model_clear();
            end
        end
    endtask

    task automatic drive(
        input logic r, input logic s, input logic a,
        input logic [2:0] x, input logic [2:0] y
    );
        reset = r;
        start = s;
        round_ack = a;
        p1_btn = x;
        p2_btn = y;
        model_step(r, s, a, x, y);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string name, input logic [7:0] act, input logic [7:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {p1_move, p2_move, p1_locked, p2_locked,
                round_valid, busy};
    endfunction

    typedef struct {
        logic       r;
        logic       s;
        logic       a;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic r, input logic s, input logic a,
        input logic [2:0] x, input logic [2:0] y,
        input logic [1:0] m1, input logic [1:0] m2,
        input logic l1, input logic l2, input logic rv, input logic bz
    );
        vec_t v;
        v.r = r; v.s = s; v.a = a; v.x = x; v.y = y;
        v.e = {m1, m2, l1, l2, rv, bz};
        vecs.push_back(v);
    endtask

    initial begin
        int  any;
        int  h1c;
        int  h2c;
        logic [2:0] b1;
        logic [2:0] b2;
        logic r;
        reset = 0; start = 0; round_ack = 0;
        p1_btn = 0; p2_btn = 0;
        phase = 0;
        model_clear();

        // Basic round, handshake edges, reset in COLLECT and REVEAL.
        add(0,0,0,3'b000,3'b000, 0,0,0,0,0,0);
        add(1,1,0,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,0,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b100, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b100, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b100, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b100, 1,3,1,1,0,1);
        add(1,0,0,3'b000,3'b000, 1,3,1,1,1,1);
        add(1,0,1,3'b000,3'b000, 0,0,0,0,0,0);
        add(1,0,1,3'b000,3'b000, 0,0,0,0,0,0);
        add(1,1,0,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,1,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,1,3'b010,3'b010, 0,0,0,0,0,1);
        add(1,0,1,3'b010,3'b010, 0,0,0,0,0,1);
        add(1,0,1,3'b010,3'b010, 0,0,0,0,0,1);
        add(1,0,1,3'b010,3'b010, 2,2,1,1,0,1);
        add(1,1,0,3'b000,3'b000, 2,2,1,1,1,1);
        add(1,1,0,3'b000,3'b000, 2,2,1,1,1,1);
        add(1,1,1,3'b000,3'b000, 0,0,0,0,0,0);
        add(1,0,0,3'b000,3'b000, 0,0,0,0,0,0);
        add(1,1,0,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,0,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,0,3'b100,3'b000, 0,0,0,0,0,1);
        add(1,0,0,3'b100,3'b000, 0,0,0,0,0,1);
        add(0,0,0,3'b100,3'b000, 0,0,0,0,0,0);
        add(1,0,0,3'b100,3'b000, 0,0,0,0,0,0);
        add(1,1,0,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,0,3'b000,3'b000, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b001, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b001, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b001, 0,0,0,0,0,1);
        add(1,0,0,3'b001,3'b001, 1,1,1,1,0,1);
        add(1,0,0,3'b000,3'b000, 1,1,1,1,1,1);
        add(0,0,0,3'b000,3'b000, 0,0,0,0,0,0);
        add(1,0,0,3'b000,3'b000, 0,0,0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].x, vecs[i].y);
            chk($sformatf("vec%0d", i), outs(), vecs[i].e);
        end

        // Bounce then stable press.
        drive(0,0,0,0,0);
        drive(1,1,0,0,0);
        drive(1,0,0,0,0);
        any = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1,0,0,(i % 2 == 0) ? 3'b001 : 3'b000, 0);
            if (p1_locked) any = 1;
        end
        chk("bounce_nolock", 8'(any), 8'd0);
        for (int i = 0; i < 3; i++) drive(1,0,0,3'b001,0);
        chk("bounce_early", {7'd0, p1_locked}, 8'd0);
        drive(1,0,0,3'b001,0);
        chk("bounce_lock", {5'd0, p1_move, p1_locked}, 8'b011);

        // Two buttons at once never lock.
        drive(0,0,0,0,0);
        drive(1,1,0,0,0);
        drive(1,0,0,0,0);
        any = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1,0,0,3'b011,0);
            if (p1_locked) any = 1;
        end
        chk("multi_nolock", 8'(any), 8'd0);

        // Button held through start must be released first.
        drive(0,0,0,0,3'b010);
        drive(1,1,0,0,3'b010);
        for (int i = 0; i < 8; i++) drive(1,0,0,0,3'b010);
        chk("held_nolock", {7'd0, p2_locked}, 8'd0);
        drive(1,0,0,0,0);
        for (int i = 0; i < 3; i++) drive(1,0,0,0,3'b010);
        chk("held_early", {7'd0, p2_locked}, 8'd0);
        drive(1,0,0,0,3'b010);
        chk("held_lock", {5'd0, p2_move, p2_locked}, 8'b101);

        // Locked move persists while the other player is pending.
        drive(0,0,0,0,0);
        drive(1,1,0,0,0);
        drive(1,0,0,0,0);
        for (int i = 0; i < 4; i++) drive(1,0,0,3'b001,0);
        chk("persist_lock", {5'd0, p1_move, p1_locked}, 8'b011);
        for (int i = 0; i < 10; i++) drive(1,0,0,3'b010,0);
        chk("persist_move", {6'd0, p1_move}, 8'd1);
        chk("persist_rv", {7'd0, round_valid}, 8'd0);
        for (int i = 0; i < 4; i++) drive(1,0,0,3'b010,3'b100);
        chk("persist_p2", outs(), {2'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1});
        drive(1,0,0,0,0);
        chk("persist_rv1", outs(), {2'd1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1});
        drive(1,0,1,0,0);
        chk("persist_ack", outs(), 8'd0);

        // Randomized traffic against the reference model.
        drive(0,0,0,0,0);
        b1 = 0; b2 = 0; h1c = 0; h2c = 0;
        for (int i = 0; i < 4000; i++) begin
            if (h1c == 0) begin
                any = $urandom_range(0, 99);
                b1 = (any < 40) ? 3'b000 :
                     (any < 85) ? 3'(1 << $urandom_range(0, 2)) :
                     3'($urandom_range(0, 7));
                h1c = $urandom_range(1, 6);
            end
            if (h2c == 0) begin
                any = $urandom_range(0, 99);
                b2 = (any < 40) ? 3'b000 :
                     (any < 85) ? 3'(1 << $urandom_range(0, 2)) :
                     3'($urandom_range(0, 7));
                h2c = $urandom_range(1, 6);
            end
            h1c--;
            h2c--;
            r = ($urandom_range(0, 149) != 0);
            drive(r, ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), b1, b2);
            chk($sformatf("rand%0d", i), outs(),
                {mv[0], mv[1], lk[0], lk[1],
                 phase == 2, phase != 0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rps_move_arbiter.md
# rps_move_arbiter

Collects one move per player for a rock-paper-scissors round from the synchronized button vectors that leave the per-button input flops. Debounces and validates each player's buttons, locks the first clean press, and presents both moves together with a valid/ack handshake to the round-scoring logic. Sits between the input synchronizers and the game/score datapath, and sequences rounds as IDLE → COLLECT → REVEAL.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive identical valid samples required to lock a move; legal range 2..1024.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clk; 0 = reset.
- p1_btn  input  3  player 1 buttons {scissors, paper, rock}, already synchronized.
- p2_btn  input  3  player 2 buttons, same encoding.
- start  input  1  arms a new round; honoured only in IDLE.
- round_ack  input  1  consumer accepts revealed moves; honoured only while round_valid=1.
- p1_move  output  2  locked move: 0 none, 1 rock, 2 paper, 3 scissors.
- p2_move  output  2  same encoding.
- p1_locked, p2_locked  output  1 each  player move captured this round.
- round_valid  output  1  both moves valid and stable.
- busy  output  1  state ≠ IDLE.

## Operation
- Reset (reset=0 at posedge): state IDLE. All outputs 0 (p*_move=0, p*_locked=0, round_valid=0, busy=0). Debounce counters and arm flags cleared. Applies from any state, including mid-debounce and during REVEAL.
- IDLE: buttons ignored. start=1 → COLLECT.
- COLLECT: each player is handled independently by a debouncer:
  - Arming: a player's press counts only after that player's btn=000 has been sampled for at least one cycle in COLLECT. A button held through start therefore never locks.
  - Valid sample: exactly one bit set. 000, or two or more bits set, clears the counter.
  - The counter increments while the sample is valid and equal to the previous sample. Any change reloads the count to 1 for the new valid vector, or 0 if invalid.
  - Lock: when the count reaches DEBOUNCE_CYCLES, p*_move takes the encoded move and p*_locked=1. Once locked, that player's inputs are ignored until the next round.
  - When both players are locked, whether in the same or different cycles, the state moves to REVEAL.
- REVEAL: round_valid=1. p*_move and p*_locked are held constant. round_ack=1 → IDLE, which clears p*_move, p*_locked and round_valid.
- Ignored events: start outside IDLE; round_ack outside REVEAL. start and round_ack together in REVEAL: the ack is taken and start is dropped, so a fresh start is needed in IDLE.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.

## Timing
- A stable valid press first sampled at edge t, with the arm condition already met, gives p*_locked=1 after edge t+DEBOUNCE_CYCLES-1, visible in cycle t+DEBOUNCE_CYCLES-1.
- round_valid rises one cycle after the later of p1_locked/p2_locked rises.
- round_ack sampled at edge e gives round_valid=0, busy=0 and moves=0 in the cycle after e.
- start sampled at edge s gives busy=1 in the cycle after s.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package rps_pkg holds:
  - move_t: 2-bit enum NONE/ROCK/PAPER/SCISSORS.
  - arb_state_t: IDLE/COLLECT/REVEAL.
  - Function onehot_to_move(3-bit) returning move_t; NONE for invalid input.
- Sub-module move_debouncer, instantiated twice. Ports: clk, reset, enable (COLLECT), clear (return to IDLE), btn[2:0], move, locked. It contains the arm flag, previous-sample register and counter.
- The top level holds the FSM and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Basic round: start; both buttons 000 for 1 cycle; p1_btn=001 and p2_btn=100 held 4 cycles → p1_move=1, p2_move=3, both locked; round_valid one cycle later; round_ack → all outputs 0 and busy=0 next cycle.
- Bounce: p1_btn toggles 001/000 each cycle for 10 cycles, then held 001 → lock exactly 4 cycles after the last change. p1_btn=011 held 20 cycles → never locks.
- Held through start: p2_btn=010 held before and after start → no lock. Release to 000 for 1 cycle, press 010 for 4 cycles → p2_move=2.
- Lock persistence: p1 locks rock, then presses paper for 10 cycles → p1_move stays 1. round_valid waits for p2.
- Handshake edges: round_ack in IDLE/COLLECT → no effect. start during REVEAL → ignored. start and ack in the same cycle → IDLE, and a second start is required.
- Reset mid-operation: reset=0 for one edge during COLLECT with partial count, and again during REVEAL → all outputs 0 next cycle; start alone does not resume the previous round.
